fixed_point_square: RTL and testbench
=====================================

# fixed_point_square

Iterative unsigned fixed-point squarer, the inverse of the LUT square-root unit in the arithmetic datapath. It accepts one WIDTH-bit operand in scale-SCALE fixed point and computes the operand squared with a radix-2 shift-and-add loop. It returns the result in the same fixed-point format, with truncation and saturation. It sits beside the square-root unit in the execution stage; normalisation and magnitude paths use it to re-square roots.

## Interface
- WIDTH, 32: operand and result width in bits.
- SCALE, 17: number of fractional bits in the operand and result.
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- iInputReady  in  1  request strobe; Operand is sampled on any edge where iInputReady=1 and the block is idle.
- Operand  in  WIDTH  unsigned fixed-point value, scale SCALE.
- oBusy  out  1  high while a computation is in progress (state != IDLE).
- OutputReady  out  1  one-cycle pulse marking a valid Result.
- Result  out  WIDTH  squared value, scale SCALE; holds until the next completion.
- oOverflow  out  1  set when the square exceeded WIDTH bits and Result was saturated; valid with Result.

## Operation
- Reset values: state=IDLE, oBusy=0, OutputReady=0, Result=0, oOverflow=0. The internal accumulator, counter and operand registers are cleared.
- **IDLE.** If iInputReady=1 at an edge:
  - latch Operand into both the multiplicand and the multiplier registers;
  - clear the 2*WIDTH-bit accumulator and the bit counter;
  - go to CALC.
  - If iInputReady=0, stay in IDLE.
- **CALC.** One edge per multiplier bit, LSB first.
  - If multiplier bit[counter]=1: accumulator += multiplicand << counter.
  - counter increments each edge.
  - The edge that processes bit WIDTH-1 moves the block to DONE.
  - CALC lasts exactly WIDTH edges. There is no early exit; latency is fixed regardless of operand value.
- **DONE.** On one edge:
  - register Result and oOverflow;
  - set OutputReady=1 for the following cycle;
  - return to IDLE.
- **Arithmetic.** The product P is 2*WIDTH bits at scale 2*SCALE.
  - Nominal result = P[WIDTH+SCALE-1:SCALE], i.e. truncated toward zero; dropped fractional bits are discarded with no rounding.
  - If any bit of P[2*WIDTH-1:WIDTH+SCALE] is set: Result = all ones, oOverflow = 1.
  - Otherwise oOverflow = 0.
- **iInputReady while oBusy=1:** ignored and not queued. The in-flight operation is unaffected.
- **Operand changing during CALC:** has no effect, because the operand is latched.
- **Reset asserted mid-operation:** aborts immediately to the reset values. No OutputReady is produced for the aborted operation.
- **Back-to-back requests:** allowed. In the OutputReady cycle the state is already IDLE (oBusy=0), so iInputReady=1 in that cycle starts the next operation at the following edge.
- OutputReady is never high for more than one consecutive cycle.

## Timing
- Edge T (accept) samples iInputReady=1 in IDLE.
- oBusy=1 from after edge T through the cycle after edge T+WIDTH.
- Edge T+WIDTH+1 (DONE) registers the outputs.
- OutputReady=1, with Result and oOverflow valid, in the cycle after edge T+WIDTH+1. That is 33 cycles after the accepting edge at WIDTH=32.
- oBusy=0 in the OutputReady cycle.
- Minimum issue interval: WIDTH+2 cycles.
- No combinational path exists from any input to any output; all outputs are registered.

## Test plan
- Reset then idle: hold Reset for 2 cycles, with iInputReady=1 during reset. All outputs must read 0, and no OutputReady pulse may follow reset release unless a new request is made.
- Exact squares, at 33-cycle latency with oOverflow=0:
  - Operand 32'h40000 (2.0) -> Result 32'h80000.
  - Operand 32'h30000 (1.5) -> Result 32'h48000.
  - Operand 32'h10000 (0.5) -> Result 32'h8000.
- Round trip and truncation:
  - Operand 32'h2d413 (the sqrt(2) LUT value) -> Result 32'h3fffd.
  - Operand 32'h1 -> Result 0, oOverflow=0.
- Overflow boundary:
  - Operand 32'h1000000 (128.0) -> Result 32'h80000000, oOverflow=0.
  - Operand 32'h2000000 (256.0) -> Result 32'hffffffff, oOverflow=1.
- Busy and back-to-back handling:
  - Pulse iInputReady with Operand 32'h40000, then pulse again at cycle +10 with 32'h60000. The second request must be ignored: one OutputReady only, Result 32'h80000.
  - Then assert iInputReady during the OutputReady cycle with 32'h60000. The next Result must be 32'h120000, 33 cycles later.
- Reset mid-operation: start with 32'h40000 and assert Reset at cycle +15. There must be no OutputReady, and Result and oBusy must read 0. A new request with 32'h30000 afterwards must yield 32'h48000 normally.

Source files
------------

// File: rtl/fixed_point_square.sv
// fixed_point_square: iterative shift-and-add squarer for unsigned fixed point,
// truncating the scaled product and saturating when it exceeds WIDTH bits.
module fixed_point_square #(
    parameter int WIDTH = 32,
    parameter int SCALE = 17
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iInputReady,
    input  logic [WIDTH-1:0] Operand,
    output logic             oBusy,
    output logic             OutputReady,
    output logic [WIDTH-1:0] Result,
    output logic             oOverflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   ovf_q, ovf_d;
    logic                   rdy_q, rdy_d;
    logic [2*WIDTH-1:0]     scaled;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = iInputReady ? CALC : IDLE;
            CALC:    state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : CALC;
            default: state_d = IDLE;
        endcase
    end

    // Product sits at scale 2*SCALE; shifting by SCALE realigns it, and any
    // set bit above WIDTH means the square does not fit.
    always_comb begin
        scaled   = acc_q >> SCALE;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        rdy_d    = 1'b0;
        if (state_q == IDLE && iInputReady) begin
            mcand_d  = Operand;
            mplier_d = Operand;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == CALC) begin
            acc_d = acc_q + (mplier_q[cnt_q] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0);
            cnt_d = cnt_q + 1'b1;
        end else if (state_q == DONE) begin
            ovf_d    = |scaled[2*WIDTH-1:WIDTH];
            result_d = ovf_d ? '1 : scaled[WIDTH-1:0];
            rdy_d    = 1'b1;
        end
    end

    always_comb begin
        oBusy       = state_q != IDLE;
        OutputReady = rdy_q;
        Result      = result_q;
        oOverflow   = ovf_q;
    end
endmodule

// File: tb/tb_fixed_point_square.sv
// tb_fixed_point_square: directed vectors with hand-computed squares,
// checking latency, truncation, saturation, busy rejection and reset abort.
module tb_fixed_point_square;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iInputReady = 1'b0;
    logic [31:0] Operand = '0;
    logic        oBusy;
    logic        OutputReady;
    logic [31:0] Result;
    logic        oOverflow;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat;
    int          pulses;
    logic        prev_rdy = 1'b0;

    fixed_point_square #(.WIDTH(32), .SCALE(17)) dut (
        .Clock(Clock), .Reset(Reset), .iInputReady(iInputReady), .Operand(Operand),
        .oBusy(oBusy), .OutputReady(OutputReady), .Result(Result), .oOverflow(oOverflow)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the request is sampled on the next rising edge.
    task automatic issue(input logic [31:0] op);
        iInputReady = 1'b1;
        Operand = op;
        @(posedge Clock);
        #1 iInputReady = 1'b0;
        Operand = 32'hdeadbeef;
    endtask

    // Returns the number of rising edges since the accepting edge.
    task automatic wait_done(output int l);
        l = 0;
        @(negedge Clock);
        while (!OutputReady && l < 100) begin
            l++;
            @(negedge Clock);
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge Clock);
            if (OutputReady) n++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] op, input logic [31:0] exp_res,
                       input logic exp_ovf);
        issue(op);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd33);
        chk({tag, "_result"}, Result, exp_res);
        chk({tag, "_ovf"}, {31'd0, oOverflow}, {31'd0, exp_ovf});
        chk({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
    endtask

    always @(negedge Clock) begin
        if (OutputReady) chk("pulse_width", {31'd0, prev_rdy}, 32'd0);
        prev_rdy <= OutputReady;
    end

    initial begin
        iInputReady = 1'b1;
        Operand = 32'h40000;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        iInputReady = 1'b0;
        chk("rst_busy", {31'd0, oBusy}, 32'd0);
        chk("rst_rdy", {31'd0, OutputReady}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_ovf", {31'd0, oOverflow}, 32'd0);
        count_pulses(40, pulses);
        chk("rst_no_pulse", 32'(pulses), 32'd0);

        run("sq_2p0", 32'h40000, 32'h80000, 1'b0);
        repeat (3) @(negedge Clock);
        run("sq_1p5", 32'h30000, 32'h48000, 1'b0);
        repeat (3) @(negedge Clock);
        run("sq_0p5", 32'h10000, 32'h8000, 1'b0);
        repeat (3) @(negedge Clock);
        run("sqrt2_trip", 32'h2d413, 32'h3fffd, 1'b0);
        repeat (3) @(negedge Clock);
        run("lsb_trunc", 32'h1, 32'h0, 1'b0);
        repeat (3) @(negedge Clock);
        run("edge_128", 32'h1000000, 32'h80000000, 1'b0);
        repeat (3) @(negedge Clock);
        run("sat_256", 32'h2000000, 32'hffffffff, 1'b1);
        repeat (3) @(negedge Clock);

        // Second request lands while busy and must be dropped.
        issue(32'h40000);
        repeat (9) @(negedge Clock);
        chk("busy_mid", {31'd0, oBusy}, 32'd1);
        issue(32'h60000);
        wait_done(lat);
        chk("ignored_latency", 32'(lat), 32'd24);
        chk("ignored_result", Result, 32'h80000);
        chk("ignored_ovf", {31'd0, oOverflow}, 32'd0);
        issue(32'h60000);
        chk("b2b_rdy_drop", {31'd0, OutputReady}, 32'd0);
        chk("b2b_busy", {31'd0, oBusy}, 32'd1);
        wait_done(lat);
        chk("b2b_latency", 32'(lat), 32'd33);
        chk("b2b_result", Result, 32'h120000);
        count_pulses(40, pulses);
        chk("b2b_no_extra", 32'(pulses), 32'd0);

        issue(32'h40000);
        repeat (14) @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        chk("abort_busy", {31'd0, oBusy}, 32'd0);
        chk("abort_result", Result, 32'd0);
        chk("abort_ovf", {31'd0, oOverflow}, 32'd0);
        count_pulses(40, pulses);
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        run("after_abort", 32'h30000, 32'h48000, 1'b0);

        repeat (3) @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
